// File: rtl/vga_pkg.sv
// Shared VGA definitions: standard mode timings, pixel colour type and a clamp helper.
package vga_pkg;

  localparam int VGA_COLOR_W = 4;

  // 800x600@60 (the default mode)
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;

  // 640x480@60
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_H_ACTIVE  = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam int VGA_V_ACTIVE  = 480;
  localparam int VGA_V_FP      = 10;

  typedef struct packed {
    logic [VGA_COLOR_W-1:0] r;
    logic [VGA_COLOR_W-1:0] g;
    logic [VGA_COLOR_W-1:0] b;
  } rgb_t;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/vga_cursor_overlay_if.sv
// Mouse-in / VGA-out signal bundle of the cursor overlay; slave is the overlay side.
interface vga_cursor_overlay_if #(
  parameter int COLOR_W = 4,
  parameter int DELTA_W = 9,
  parameter int X_W     = 10,
  parameter int Y_W     = 10
);
  logic               iMoveValid;
  logic [DELTA_W-1:0] iDx;
  logic [DELTA_W-1:0] iDy;
  logic [2:0]         iButton;
  logic               oHs;
  logic               oVs;
  logic [COLOR_W-1:0] oRed;
  logic [COLOR_W-1:0] oGreen;
  logic [COLOR_W-1:0] oBlue;
  logic               oActive;
  logic               oFrameStart;
  logic [X_W-1:0]     oCursorX;
  logic [Y_W-1:0]     oCursorY;

  modport master (
    output iMoveValid, iDx, iDy, iButton,
    input  oHs, oVs, oRed, oGreen, oBlue, oActive, oFrameStart, oCursorX, oCursorY
  );

  modport slave (
    input  iMoveValid, iDx, iDy, iButton,
    output oHs, oVs, oRed, oGreen, oBlue, oActive, oFrameStart, oCursorX, oCursorY
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters plus registered sync/active outputs; px/py/active_c are the unregistered
// counter-stage view so the caller can register colour in the same stage as the syncs.
module vga_timing_gen #(
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter bit SYNC_POL = 1'b0,
  parameter int X_W      = 10,
  parameter int Y_W      = 10
) (
  input  logic           clk,
  input  logic           srst,
  output logic           hs,
  output logic           vs,
  output logic           active,
  output logic           active_c,
  output logic [X_W-1:0] px,
  output logic [Y_W-1:0] py,
  output logic           frame_start
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int H_END   = H_START + H_ACTIVE;
  localparam int V_END   = V_START + V_ACTIVE;

  logic [HC_W-1:0] h_cnt_reg, h_cnt_next;
  logic [VC_W-1:0] v_cnt_reg, v_cnt_next;
  logic            hs_reg, vs_reg, active_reg, frame_start_reg;
  logic            h_wrap;

  always_comb begin
    h_wrap     = (int'(h_cnt_reg) == H_TOTAL - 1);
    h_cnt_next = h_wrap ? '0 : h_cnt_reg + HC_W'(1);
    v_cnt_next = v_cnt_reg;
    if (h_wrap) begin
      v_cnt_next = (int'(v_cnt_reg) == V_TOTAL - 1) ? '0 : v_cnt_reg + VC_W'(1);
    end
  end

  assign active_c = (int'(h_cnt_reg) >= H_START) && (int'(h_cnt_reg) < H_END) &&
                    (int'(v_cnt_reg) >= V_START) && (int'(v_cnt_reg) < V_END);
  assign px = X_W'(int'(h_cnt_reg) - H_START);
  assign py = Y_W'(int'(v_cnt_reg) - V_START);

  // frame_start is registered from the next count so it is high exactly while
  // the counters sit at (0,0), yet stays low in the first cycle after reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      h_cnt_reg       <= '0;
      v_cnt_reg       <= '0;
      hs_reg          <= !SYNC_POL;
      vs_reg          <= !SYNC_POL;
      active_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      h_cnt_reg       <= h_cnt_next;
      v_cnt_reg       <= v_cnt_next;
      hs_reg          <= (int'(h_cnt_reg) < H_SYNC) ? SYNC_POL : !SYNC_POL;
      vs_reg          <= (int'(v_cnt_reg) < V_SYNC) ? SYNC_POL : !SYNC_POL;
      active_reg      <= active_c;
      frame_start_reg <= (h_cnt_next == '0) && (v_cnt_next == '0);
    end
  end

  assign hs          = hs_reg;
  assign vs          = vs_reg;
  assign active      = active_reg;
  assign frame_start = frame_start_reg;
endmodule

// File: rtl/vga_cursor_overlay.sv
// Cursor overlay top: accumulates mouse motion, commits it once per frame and paints the cursor.
// Build option: define VGA_CURSOR_OUTLINE_EN to draw a 1-pixel black ring around the cursor.
module vga_cursor_overlay
  import vga_pkg::*;
#(
  parameter int H_SYNC   = SVGA_H_SYNC,
  parameter int H_BP     = SVGA_H_BP,
  parameter int H_ACTIVE = SVGA_H_ACTIVE,
  parameter int H_FP     = SVGA_H_FP,
  parameter int V_SYNC   = SVGA_V_SYNC,
  parameter int V_BP     = SVGA_V_BP,
  parameter int V_ACTIVE = SVGA_V_ACTIVE,
  parameter int V_FP     = SVGA_V_FP,
  parameter bit SYNC_POL = 1'b0,
  parameter int COLOR_W  = VGA_COLOR_W,
  parameter int DELTA_W  = 9,
  parameter int CUR_SIZE = 8,
  parameter logic [3*COLOR_W-1:0] BG_RGB = {4'hF, 4'h0, 4'h0}
) (
  input logic                 iClk,
  input logic                 iRst,
  vga_cursor_overlay_if.slave bus
);
  localparam int X_W   = $clog2(H_ACTIVE);
  localparam int Y_W   = $clog2(V_ACTIVE);
  localparam int ACC_W = DELTA_W + 4;
  localparam int X_MAX = H_ACTIVE - CUR_SIZE;
  localparam int Y_MAX = V_ACTIVE - CUR_SIZE;
  localparam logic [COLOR_W-1:0] FULL = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] NONE = '0;

  logic                    active_c, frame_start, hit;
  logic [X_W-1:0]          px, cur_x_reg;
  logic [Y_W-1:0]          py, cur_y_reg;
  logic signed [ACC_W-1:0] pend_x_reg, pend_y_reg, dx_ext, dy_neg;
  logic [2:0]              button_reg;
  logic [3*COLOR_W-1:0]    pix_next, pix_reg;

  vga_timing_gen #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
    .SYNC_POL(SYNC_POL), .X_W(X_W), .Y_W(Y_W)
  ) u_timing (
    .clk(iClk), .srst(iRst), .hs(bus.oHs), .vs(bus.oVs), .active(bus.oActive),
    .active_c(active_c), .px(px), .py(py), .frame_start(frame_start)
  );

  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  // Y is negated on entry so the accumulator and cursor both grow downwards.
  assign dx_ext = ACC_W'(signed'(bus.iDx));
  assign dy_neg = -ACC_W'(signed'(bus.iDy));

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cur_x_reg  <= X_W'(X_MAX / 2);
      cur_y_reg  <= Y_W'(Y_MAX / 2);
      pend_x_reg <= '0;
      pend_y_reg <= '0;
      button_reg <= '0;
    end else begin
      if (frame_start) begin
        cur_x_reg  <= X_W'(clamp(int'(cur_x_reg) + int'(pend_x_reg), 0, X_MAX));
        cur_y_reg  <= Y_W'(clamp(int'(cur_y_reg) + int'(pend_y_reg), 0, Y_MAX));
        pend_x_reg <= bus.iMoveValid ? dx_ext : '0;
        pend_y_reg <= bus.iMoveValid ? dy_neg : '0;
      end else if (bus.iMoveValid) begin
        pend_x_reg <= sat_add(pend_x_reg, dx_ext);
        pend_y_reg <= sat_add(pend_y_reg, dy_neg);
      end
      if (bus.iMoveValid) button_reg <= bus.iButton;
    end
  end

  assign hit = (px >= cur_x_reg) && ({1'b0, px} < {1'b0, cur_x_reg} + (X_W+1)'(CUR_SIZE)) &&
               (py >= cur_y_reg) && ({1'b0, py} < {1'b0, cur_y_reg} + (Y_W+1)'(CUR_SIZE));

`ifdef VGA_CURSOR_OUTLINE_EN
  logic ring;
  assign ring = (px == cur_x_reg) || ({1'b0, px} == {1'b0, cur_x_reg} + (X_W+1)'(CUR_SIZE - 1)) ||
                (py == cur_y_reg) || ({1'b0, py} == {1'b0, cur_y_reg} + (Y_W+1)'(CUR_SIZE - 1));
`endif

  always_comb begin
    pix_next = '0;
    if (active_c) begin
      pix_next = BG_RGB;
      if (hit) begin
        if (button_reg[0])      pix_next = {NONE, FULL, NONE};
        else if (button_reg[1]) pix_next = {NONE, NONE, FULL};
        else                    pix_next = {FULL, FULL, FULL};
`ifdef VGA_CURSOR_OUTLINE_EN
        if (ring) pix_next = '0;
`endif
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) pix_reg <= '0;
    else      pix_reg <= pix_next;
  end

  assign bus.oRed        = pix_reg[3*COLOR_W-1 -: COLOR_W];
  assign bus.oGreen      = pix_reg[2*COLOR_W-1 -: COLOR_W];
  assign bus.oBlue       = pix_reg[COLOR_W-1 -: COLOR_W];
  assign bus.oFrameStart = frame_start;
  assign bus.oCursorX    = cur_x_reg;
  assign bus.oCursorY    = cur_y_reg;
endmodule

// File: tb/tb_vga_cursor_overlay.sv
// Bench for vga_cursor_overlay on a small raster: every cycle is compared with a frame-level
// model (raster position from the cycle index, cursor from per-frame accumulated motion).
module tb_vga_cursor_overlay;
  localparam int HS = 4, HBP = 3, HA = 40, HFP = 2;
  localparam int VS = 2, VBP = 2, VA = 30, VFP = 1;
  localparam int HT = HS + HBP + HA + HFP;
  localparam int VT = VS + VBP + VA + VFP;
  localparam int F  = HT * VT;
  localparam int CS = 8;
  localparam int XMAX = HA - CS, YMAX = VA - CS;
  localparam int X0 = XMAX / 2, Y0 = YMAX / 2;
  localparam int X_W = $clog2(HA), Y_W = $clog2(VA);
  localparam int ACC_MAX = 4095, ACC_MIN = -4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_cursor_overlay_if #(.COLOR_W(4), .DELTA_W(9), .X_W(X_W), .Y_W(Y_W)) bus ();

  vga_cursor_overlay #(
    .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP),
    .SYNC_POL(1'b0), .COLOR_W(4), .DELTA_W(9), .CUR_SIZE(CS), .BG_RGB(12'hF00)
  ) dut (
    .iClk(clk), .iRst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int k = 0;
  int cx, cy, pend_x, pend_y;
  logic [2:0]  btn;
  logic [14:0] exp_out;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic chk_cursor(input string tag, input int x, input int y);
    check_eq(tag, 32'({bus.oCursorX, bus.oCursorY}), 32'({X_W'(x), Y_W'(y)}));
  endtask

  function automatic int sat(input int v);
    return (v > ACC_MAX) ? ACC_MAX : ((v < ACC_MIN) ? ACC_MIN : v);
  endfunction

  function automatic int lim(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  // Expected {hs, vs, active, rgb} for the raster position reached c cycles after reset.
  function automatic logic [14:0] model_out(input int c, input int x, input int y, input logic [2:0] b);
    int h, v, px, py;
    logic act;
    logic [11:0] rgb;
    h = c % HT;
    v = (c / HT) % VT;
    px = h - (HS + HBP);
    py = v - (VS + VBP);
    act = (px >= 0) && (px < HA) && (py >= 0) && (py < VA);
    rgb = 12'h000;
    if (act) begin
      rgb = 12'hF00;
      if (px >= x && px < x + CS && py >= y && py < y + CS) begin
        rgb = b[0] ? 12'h0F0 : (b[1] ? 12'h00F : 12'hFFF);
`ifdef VGA_CURSOR_OUTLINE_EN
        if (px == x || px == x + CS - 1 || py == y || py == y + CS - 1) rgb = 12'h000;
`endif
      end
    end
    return {(h >= HS), (v >= VS), act, rgb};
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.iMoveValid = 1'b0;
    bus.iDx = '0;
    bus.iDy = '0;
    bus.iButton = '0;
    repeat (n) @(negedge clk);
    check_eq("rst_out", 32'({bus.oHs, bus.oVs, bus.oActive, bus.oRed, bus.oGreen, bus.oBlue, bus.oFrameStart}),
             32'h0000C000);
    chk_cursor("rst_cur", X0, Y0);
    k = 0; cx = X0; cy = Y0; pend_x = 0; pend_y = 0; btn = 3'b000;
    exp_out = 15'h6000;
    rst = 1'b0;
  endtask

  // One cycle: check this cycle's outputs, drive this cycle's move, advance the model.
  task automatic step(input bit mv, input int dx, input int dy, input logic [2:0] b);
    bit commit;
    check_eq("sync", 32'({bus.oHs, bus.oVs}), 32'(exp_out[14:13]));
    check_eq("pix", 32'({bus.oActive, bus.oRed, bus.oGreen, bus.oBlue}), 32'(exp_out[12:0]));
    check_eq("frame_start", 32'(bus.oFrameStart), 32'(k > 0 && k % F == 0));
    chk_cursor("cursor", cx, cy);
    bus.iMoveValid = mv;
    bus.iDx = 9'(dx);
    bus.iDy = 9'(dy);
    bus.iButton = b;
    exp_out = model_out(k, cx, cy, btn);
    commit = (k > 0) && (k % F == 0);
    if (commit) begin
      cx = lim(cx + pend_x, XMAX);
      cy = lim(cy + pend_y, YMAX);
      pend_x = mv ? dx : 0;
      pend_y = mv ? -dy : 0;
    end else if (mv) begin
      pend_x = sat(pend_x + dx);
      pend_y = sat(pend_y - dy);
    end
    if (mv) btn = b;
    k++;
    @(negedge clk);
  endtask

  task automatic plan(input int phase, input int f, input int p,
                      output bit mv, output int dx, output int dy, output logic [2:0] b);
    mv = 1'b0; dx = 0; dy = 0; b = 3'b000;
    if (phase == 1) begin
      if (f == 1 && (p == 100 || p == 200 || p == 300)) begin mv = 1'b1; dx = 5; dy = 3; end
      if (f == 2 && p == 50) begin mv = 1'b1; b = 3'b011; end
      if (f == 2 && p >= 100 && p < 120) begin mv = 1'b1; dx = -256; b = 3'b011; end
      if (f == 3 && p == 50) begin mv = 1'b1; b = 3'b010; end
      if (f == 3 && p >= 100 && p < 120) begin mv = 1'b1; dx = 255; dy = 255; b = 3'b010; end
      if (f == 5 && p == 0) begin mv = 1'b1; dx = -1; b = 3'b010; end
    end
    if ((phase == 1 && f >= 6) || (phase == 2 && f == 1)) begin
      if ((p == 0 && f % 2 == 1) || $urandom_range(39) == 0) begin
        mv = 1'b1;
        dx = int'($urandom_range(511)) - 256;
        dy = int'($urandom_range(511)) - 256;
        b  = 3'($urandom_range(7));
      end
    end
    if (phase == 1 && f == 12 && p == 500) begin mv = 1'b1; dx = 100; dy = -100; b = 3'b000; end
  endtask

  initial begin
    bit mv;
    int dx, dy;
    logic [2:0] b;
    do_reset(3);
    for (int f = 0; f < 13; f++) begin
      for (int p = 0; p < F; p++) begin
        if (f == 12 && p == 900) break;
        if (f == 0 && p == 809) check_eq("pix_cursor", 32'({bus.oRed, bus.oGreen, bus.oBlue}), 32'h0FFF);
        if (f == 0 && p == 807) check_eq("pix_bg", 32'({bus.oRed, bus.oGreen, bus.oBlue}), 32'h0F00);
        if (p == 1) begin
          case (f)
            2: chk_cursor("three_moves", 31, 2);
            3: chk_cursor("floor_clamp", 0, 2);
            4: chk_cursor("ceil_clamp", 32, 0);
            5: chk_cursor("commit_excl", 32, 0);
            6: chk_cursor("commit_next", 31, 0);
            default: ;
          endcase
        end
        plan(1, f, p, mv, dx, dy, b);
        step(mv, dx, dy, b);
      end
    end
    do_reset(2);
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < F; p++) begin
        if (f == 1 && p == 1) chk_cursor("reset_drops_motion", X0, Y0);
        plan(2, f, p, mv, dx, dy, b);
        step(mv, dx, dy, b);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_cursor_overlay.md
Name: vga_cursor_overlay

Overview:
- Parametrised successor of the single-mode VGA test pattern with mouse cursor.
- Generates VGA timing for any mode given by parameters on one pixel clock.
- Accumulates signed PS/2 mouse deltas, commits the cursor position once per frame (tear-free), clamps it to the active area, and draws a CUR_SIZE square cursor over a background colour.
- Sits between the PS/2 mouse decoder and the board VGA pins.

Parameters:
- H_SYNC, 128, horizontal sync pulse (pixels)
- H_BP, 88, horizontal back porch
- H_ACTIVE, 800, horizontal active pixels
- H_FP, 40, horizontal front porch
- V_SYNC, 4, vertical sync pulse (lines)
- V_BP, 23, vertical back porch
- V_ACTIVE, 600, vertical active lines
- V_FP, 1, vertical front porch
- SYNC_POL, 0, sync active level (0 = active-low)
- COLOR_W, 4, bits per colour channel
- DELTA_W, 9, width of signed mouse delta (two's complement)
- CUR_SIZE, 8, cursor edge length in pixels (1..64)
- BG_RGB, {4'hF,4'h0,4'h0}, background colour {R,G,B}

Ports:
- iClk  in  1  pixel clock
- iRst  in  1  synchronous active-high reset
- iMoveValid  in  1  one-cycle strobe: iDx/iDy/iButton valid
- iDx  in  DELTA_W  signed X delta, +ve = right
- iDy  in  DELTA_W  signed Y delta, +ve = up (PS/2 convention)
- iButton  in  3  {middle,right,left}, sampled with iMoveValid
- oHs  out  1  horizontal sync
- oVs  out  1  vertical sync
- oRed/oGreen/oBlue  out  COLOR_W each  pixel colour
- oActive  out  1  pixel in active area (aligned with colour)
- oFrameStart  out  1  one-cycle pulse at cursor commit
- oCursorX  out  clog2(H_ACTIVE)  committed cursor left edge
- oCursorY  out  clog2(V_ACTIVE)  committed cursor top edge

Behaviour:
- Clocking/reset: one clock, iClk; reset is synchronous and active-high (iRst).
- Reset values:
  - hCnt = vCnt = 0.
  - oHs = oVs = !SYNC_POL (inactive level).
  - Colour = 0, oActive = 0, oFrameStart = 0.
  - Cursor = ((H_ACTIVE-CUR_SIZE)/2, (V_ACTIVE-CUR_SIZE)/2).
  - Pending deltas = 0, latched buttons = 0.
- Counters:
  - H_TOTAL = sum of H params; V_TOTAL = sum of V params.
  - hCnt runs 0..H_TOTAL-1 and wraps.
  - vCnt increments only on the cycle hCnt wraps, and wraps at V_TOTAL-1.
  - Same clock domain; no clocking on derived syncs.
- Sync: HS is asserted while hCnt < H_SYNC; VS is asserted while vCnt < V_SYNC.
- Active region:
  - H_SYNC+H_BP <= hCnt < H_SYNC+H_BP+H_ACTIVE, and likewise vertically.
  - Half-open interval: exactly H_ACTIVE x V_ACTIVE pixels.
  - px = hCnt-(H_SYNC+H_BP), py = vCnt-(V_SYNC+V_BP).
- Output stage:
  - oHs, oVs, oActive and colour are all registered, giving one-cycle latency from the counters.
  - All of them share the same pipeline stage, so there is no skew.
  - Outside the active region, colour = 0.
- Delta accumulation:
  - Pending X/Y accumulators are signed, DELTA_W+4 bits, and saturate at their min/max; no wrap.
  - Y is stored negated so that +ve means down.
  - iButton is latched on every iMoveValid.
- Commit:
  - Occurs on the cycle hCnt==0 && vCnt==0; oFrameStart pulses that same cycle.
  - newX = clamp(curX + pendX, 0, H_ACTIVE-CUR_SIZE); newY is computed the same way against V_ACTIVE.
  - Clamp arithmetic uses a signed width wide enough to make overflow impossible.
  - Pending accumulators are then cleared.
  - If iMoveValid coincides with commit, that move is excluded from this commit and becomes the new pending value.
- Cursor hit: curX <= px < curX+CUR_SIZE and curY <= py < curY+CUR_SIZE.
- Cursor colour:
  - Left button (bit 0): green, all-ones G.
  - Right button (bit 1): blue.
  - Otherwise: white.
  - Left takes priority over right.
  - Outside the cursor, colour = BG_RGB.
- Reset mid-frame: the next cycle restarts the counters at 0, and pending motion is discarded.

Optional Feature:
- Macro: VGA_CURSOR_OUTLINE_EN.
- Defined: the cursor's outermost 1-pixel ring (px==curX, px==curX+CUR_SIZE-1, py==curY, py==curY+CUR_SIZE-1) is drawn black. The interior uses the button colour.
- Undefined: the whole square uses the button colour.
- Timing and latency are identical in both builds.

Decomposition:
- Shared package vga_pkg holds:
  - Timing constants for 800x600@60 (the defaults) and 640x480@60 (96/48/640/16, 2/33/480/10).
  - rgb typedef {R,G,B} of COLOR_W.
  - A clamp function.
- Sub-module vga_timing_gen: counters, registered syncs, active flag, px/py, frame-start flag.
- Cursor accumulation, commit and colour mux stay in the top.

Test Plan:
- Reset, then run 2 frames at default params → HS period 1056 clocks with low for 128; VS period 628 lines with low for 4; oActive high for exactly 800x600 cycles per frame.
- Cursor at reset, no moves → first frame draws the 8x8 white square at px 396..403, py 296..303; all other active pixels are BG red.
- Three moves of iDx=+10, iDy=+5 in one frame → at next oFrameStart, oCursorX=426 and oCursorY=281.
- iDx=-256 repeated 10 times → oCursorX=0 after commit (floor clamp); then iDx=+255 repeated 10 times → oCursorX=792 (ceiling clamp); no wrap.
- iMoveValid with iDx=+1 on the commit cycle → current commit ignores it; the following frame adds 1.
- iButton=3'b011 → cursor green; iButton=3'b010 → blue; with VGA_CURSOR_OUTLINE_EN the border pixels are black.
